// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared WS2812 timing derivations and FSM state encoding
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_GAP  = 2'd0,
    ST_LOAD = 2'd1,
    ST_BIT  = 2'd2
  } state_t;

  function automatic int t_bit(input int mhz);
    return mhz * 5 / 4;
  endfunction

  function automatic int t0h(input int mhz);
    return mhz * 35 / 100;
  endfunction

  function automatic int t1h(input int mhz);
    return mhz * 7 / 10;
  endfunction

  function automatic int t_rst(input int mhz);
    return mhz * 80;
  endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// ws2812_bit_encoder: bit-period counter and registered high/low waveform for one WS2812 bit
module ws2812_bit_encoder #(
  parameter int T_BIT = 15,
  parameter int T0H   = 4,
  parameter int T1H   = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_bit_start,
  input  logic i_bit,
  output logic o_data,
  output logic o_bit_last
);

  localparam int CW = $clog2(T_BIT);
  localparam logic [CW-1:0] C_LAST = CW'(T_BIT - 1);
  localparam logic [CW:0] TH0 = (CW + 1)'(T0H);
  localparam logic [CW:0] TH1 = (CW + 1)'(T1H);

  logic [CW-1:0] r_cnt;
  logic          r_run;
  logic          r_data;
  logic [CW-1:0] w_cnt_inc;
  logic [CW:0]   w_th;
  logic          w_cont;

  assign w_cnt_inc  = r_cnt + CW'(1);
  assign w_th       = i_bit ? TH1 : TH0;
  assign o_bit_last = r_run && (r_cnt == C_LAST);
  assign w_cont     = r_run && !o_bit_last;
  assign o_data     = r_data;

  // data is computed from the counter value it will accompany, so the line is high from count 0
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_data <= 1'b0;
    end else begin
      r_run  <= i_bit_start || w_cont;
      r_cnt  <= i_bit_start ? '0 : w_cont ? w_cnt_inc : '0;
      r_data <= i_bit_start || (w_cont && ({1'b0, w_cnt_inc} < w_th));
    end
  end

endmodule

// File: rtl/ws2812_tx.sv
// ws2812_tx: WS2812 pixel-chain transmitter with reset gap, frame shadow and continuous refresh
module ws2812_tx
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 16,
  parameter int CLK_MHZ  = 12
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    enable,
  input  logic [24*NUM_LEDS-1:0]  packed_rgb_data,
  output logic                    data,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int TB = t_bit(CLK_MHZ);
  localparam int T0 = t0h(CLK_MHZ);
  localparam int T1 = t1h(CLK_MHZ);
  localparam int TR = t_rst(CLK_MHZ);
  localparam int LW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int GW = $clog2(TR + 1);
  localparam logic [GW-1:0] GAP_TC   = GW'(TR - 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(TR);
  localparam logic [LW-1:0] LED_LAST = LW'(NUM_LEDS - 1);

  state_t                        r_state;
  state_t                        w_next;
  logic [GW-1:0]                 r_gap;
  logic [LW-1:0]                 r_led;
  logic [4:0]                    r_bit;
  logic [NUM_LEDS-1:0][23:0]     r_shadow;
  logic                          r_busy;
  logic                          r_done;
  logic                          w_bit_start;
  logic                          w_bit_last;
  logic                          w_done;
  logic                          w_bit;

  assign w_bit      = r_shadow[r_led][r_bit];
  assign busy       = r_busy;
  assign frame_done = r_done;

  ws2812_bit_encoder #(
    .T_BIT (TB),
    .T0H   (T0),
    .T1H   (T1)
  ) u_enc (
    .i_clk       (CLK),
    .i_rst_n     (RST_N),
    .i_bit_start (w_bit_start),
    .i_bit       (w_bit),
    .o_data      (data),
    .o_bit_last  (w_bit_last)
  );

  // next state: a gap of TR cycles, one load cycle, then back-to-back bits until the last LED's bit 0
  always_comb begin
    w_next      = ST_GAP;
    w_bit_start = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_GAP:  w_next = (r_gap >= GAP_TC && enable) ? ST_LOAD : ST_GAP;
      ST_LOAD: begin
        w_next      = ST_BIT;
        w_bit_start = 1'b1;
      end
      ST_BIT:  begin
        w_done      = w_bit_last && r_bit == 5'd0 && r_led == LED_LAST;
        w_next      = w_done ? ST_GAP : ST_BIT;
        w_bit_start = w_bit_last && !w_done;
      end
      default: w_next = ST_GAP;
    endcase
  end

  // state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_GAP;
    else        r_state <= w_next;
  end

  // gap counter, shadow capture, pixel/bit indices and registered status outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_gap    <= '0;
      r_led    <= '0;
      r_bit    <= '0;
      r_shadow <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_gap  <= (r_state != ST_GAP) ? '0 : (r_gap == GAP_MAX) ? r_gap : r_gap + GW'(1);
      r_busy <= (w_next != ST_GAP);
      r_done <= w_done;
      if (r_state == ST_LOAD) begin
        r_shadow <= packed_rgb_data;
        r_led    <= '0;
        r_bit    <= 5'd23;
      end else if (r_state == ST_BIT && w_bit_last && !w_done) begin
        r_bit <= (r_bit == 5'd0) ? 5'd23 : r_bit - 5'd1;
        if (r_bit == 5'd0) r_led <= r_led + LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ws2812_tx.sv
// tb_ws2812_tx: table-driven and model-checked bench for ws2812_tx (default and 1-LED/16 MHz builds)
module tb_ws2812_tx;

  typedef struct {
    int   cyc;
    logic en;
    logic d;
    logic b;
    logic f;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b1;
  logic [383:0] rgb1 = '0;
  logic [23:0]  rgb2 = '0;
  logic         d1, b1, f1, d2, b2, f2;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           dq1[$];
  int           dq2[$];
  vec_t         tbl[15];
  logic [23:0]  wa[16], wb[16], wc[16], wd[16], wz[16], x1[16], x2[16];

  ws2812_tx dut1 (
    .CLK(clk), .RST_N(rst_n), .enable(en), .packed_rgb_data(rgb1),
    .data(d1), .busy(b1), .frame_done(f1)
  );

  ws2812_tx #(.NUM_LEDS(1), .CLK_MHZ(16)) dut2 (
    .CLK(clk), .RST_N(rst_n), .enable(en), .packed_rgb_data(rgb2),
    .data(d2), .busy(b2), .frame_done(f2)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (f1 === 1'b1) dq1.push_back(cyc);
    if (f2 === 1'b1) dq2.push_back(cyc);
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [383:0] pack16(input logic [23:0] w[16]);
    logic [383:0] p;
    for (int i = 0; i < 16; i++) p[24*i +: 24] = w[i];
    return p;
  endfunction

  // expected line level at cycle c of a frame, straight from the bit timing rules
  function automatic logic model_bit(input logic [23:0] w[16], input int mhz, input int c);
    int tb, bn, th;
    logic [23:0] word;
    tb   = mhz * 5 / 4;
    bn   = c / tb;
    word = w[bn / 24];
    th   = word[23 - bn % 24] ? mhz * 7 / 10 : mhz * 35 / 100;
    return (c % tb) < th;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic check_frame(input string nm, input bit dut, input int start,
                             input logic [23:0] w[16], input int nleds, input int mhz,
                             input int ncyc, input int chg_off, input logic [23:0] nw[16],
                             input bit drop);
    int bad, first, len;
    logic a, e, bs, fa, fe, fb;
    bad = 0; first = -1; fa = 0; fe = 0; fb = 0;
    len = (ncyc > 0) ? ncyc : nleds * 24 * (mhz * 5 / 4);
    for (int c = 0; c < len; c++) begin
      wait_cyc(start + c);
      a  = dut ? d2 : d1;
      bs = dut ? b2 : b1;
      e  = model_bit(w, mhz, c);
      if (a !== e || bs !== 1'b1) begin
        bad++;
        if (first < 0) begin first = c; fa = a; fe = e; fb = bs; end
      end
      if (c == chg_off) begin
        if (drop) en = 1'b0;
        else      rgb1 = pack16(nw);
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d bad cycles, first at offset %0d got data=%b busy=%b, expected data=%b busy=1",
               nm, bad, first, fa, fb, fe);
    end
  endtask

  task automatic check_idle(input string nm, input int from, input int to);
    int bad;
    bad = 0;
    for (int k = from; k <= to; k++) begin
      wait_cyc(k);
      if (d1 !== 1'b0 || b1 !== 1'b0) bad++;
    end
    chk(nm, bad, 0);
  endtask

  initial begin
    tbl = '{
      '{0,    1'b1, 1'b0, 1'b0, 1'b0},
      '{959,  1'b1, 1'b0, 1'b0, 1'b0},
      '{960,  1'b1, 1'b0, 1'b1, 1'b0},
      '{961,  1'b1, 1'b1, 1'b1, 1'b0},
      '{968,  1'b1, 1'b1, 1'b1, 1'b0},
      '{969,  1'b1, 1'b0, 1'b1, 1'b0},
      '{975,  1'b1, 1'b0, 1'b1, 1'b0},
      '{976,  1'b1, 1'b1, 1'b1, 1'b0},
      '{1081, 1'b1, 1'b1, 1'b1, 1'b0},
      '{1084, 1'b1, 1'b1, 1'b1, 1'b0},
      '{1085, 1'b1, 1'b0, 1'b1, 1'b0},
      '{1095, 1'b1, 1'b0, 1'b1, 1'b0},
      '{6720, 1'b1, 1'b0, 1'b1, 1'b0},
      '{6721, 1'b1, 1'b0, 1'b0, 1'b1},
      '{6722, 1'b1, 1'b0, 1'b0, 1'b0}
    };
    for (int i = 0; i < 16; i++) begin
      wa[i] = 24'($urandom);
      wb[i] = 24'($urandom);
      wc[i] = 24'($urandom);
      wd[i] = 24'($urandom);
      wz[i] = 24'h0;
      x1[i] = 24'h0;
      x2[i] = 24'h0;
    end
    wz[0] = 24'hFF0000;
    x1[0] = 24'($urandom);
    x2[0] = 24'($urandom);
    rgb1 = pack16(wz);
    rgb2 = x1[0];
    repeat (3) @(negedge clk);
    chk("reset_data", d1, 0);
    chk("reset_busy", b1, 0);
    chk("reset_done", f1, 0);
    rst_n = 1'b1;
    fork
      begin
        for (int i = 0; i < 15; i++) begin
          wait_cyc(tbl[i].cyc);
          en = tbl[i].en;
          chk($sformatf("tbl_data@%0d", tbl[i].cyc), d1, tbl[i].d);
          chk($sformatf("tbl_busy@%0d", tbl[i].cyc), b1, tbl[i].b);
          chk($sformatf("tbl_done@%0d", tbl[i].cyc), f1, tbl[i].f);
        end
        wait_cyc(7000);
        rgb1 = pack16(wa);
        wait_cyc(7680);
        chk("gap_busy@7680", b1, 0);
        wait_cyc(7681);
        chk("load_busy@7681", b1, 1);
        chk("load_data@7681", d1, 0);
        check_frame("frame2_hold_A", 0, 7682, wa, 16, 12, 0, 3000, wb, 0);
        check_frame("frame3_B", 0, 14403, wb, 16, 12, 0, -1, wb, 0);
        wait_cyc(20164);
        chk("done_count_3", dq1.size(), 3);
        if (dq1.size() == 3) begin
          chk("done_first", dq1[0], 6721);
          chk("done_period_1", dq1[1] - dq1[0], 6721);
          chk("done_period_2", dq1[2] - dq1[1], 6721);
        end
        wait_cyc(20500);
        rgb1 = pack16(wc);
        check_frame("frame4_en_drop", 0, 21124, wc, 16, 12, 0, 2000, wb, 1);
        wait_cyc(26885);
        chk("done_count_4", dq1.size(), 4);
        if (dq1.size() == 4) chk("done_frame4", dq1[3], 26884);
        check_idle("idle_after_drop", 26885, 29884);
        en = 1'b1;
        rgb1 = pack16(wd);
        wait_cyc(29885);
        chk("reenable_load_busy", b1, 1);
        chk("reenable_load_data", d1, 0);
        chk("no_extra_done", dq1.size(), 4);
        check_frame("frame5_pre_reset", 0, 29886, wd, 16, 12, 152, -1, wb, 0);
        wait_cyc(29886 + 152);
        chk("high_before_reset", d1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_data", d1, 0);
        chk("async_reset_busy", b1, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_idle("gap_after_reset", 0, 959);
        wait_cyc(960);
        chk("load_after_reset_busy", b1, 1);
        check_frame("frame_after_reset", 0, 961, wd, 16, 12, 0, -1, wb, 0);
      end
      begin
        wait_cyc(1279);
        chk("sweep_gap_busy@1279", b2, 0);
        wait_cyc(1280);
        chk("sweep_load_busy@1280", b2, 1);
        chk("sweep_load_data@1280", d2, 0);
        check_frame("sweep_frame1", 1, 1281, x1, 1, 16, 0, -1, x1, 0);
        wait_cyc(1761);
        chk("sweep_done@1761", f2, 1);
        chk("sweep_busy@1761", b2, 0);
        wait_cyc(2000);
        rgb2 = x2[0];
        check_frame("sweep_frame2", 1, 3042, x2, 1, 16, 0, -1, x2, 0);
        wait_cyc(3523);
        chk("sweep_done_count", dq2.size(), 2);
        if (dq2.size() == 2) chk("sweep_done_period", dq2[1] - dq2[0], 1761);
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
